serial_link_lane: RTL and testbench
===================================

Name: serial_link_lane

Overview:
- Full-duplex, one-bit-per-clock serial link endpoint.
- The TX half pops 32-bit words from an upstream standard-latency FIFO and sends them as 34-bit framed symbols on tx_o.
- The RX half aligns to the incoming rx_i stream, declares channel_up, and pushes received data words into a downstream FIFO.
- The block sits between the trigger-data FIFOs and the board-to-board serial pins; a bench loops tx_o to rx_i or cross-connects two instances.

Parameters:
- DATA_W, 32, payload width; frame is DATA_W+2 bits.
- IDLE_WORD, 32'hBC50_BC50, payload of idle/control frames.
- LOCK_CNT, 8, consecutive valid idle frames required to declare channel_up.
- UNLOCK_CNT, 4, consecutive bad-header frames that drop channel_up.
- SIMULATION_P, 0, when 1 the lock threshold is 2 instead of LOCK_CNT.

Ports:
- user_clk  in  1  single clock for all logic; one line bit per cycle.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- rx_i  in  1  serial line input.
- tx_o  out  1  serial line output.
- channel_up  out  1  RX locked; gates TX data.
- fifo_data_i  in  DATA_W  upstream FIFO read data, valid the cycle after fifo_read_o.
- fifo_empty_i  in  1  upstream FIFO empty.
- fifo_read_o  out  1  upstream FIFO read strobe.
- fifo_data_o  out  DATA_W  received word.
- fifo_wren_o  out  1  one-cycle write strobe for fifo_data_o.
- fifo_full_i  in  1  downstream FIFO full.

Behaviour:
- Frame format: 2-bit header then payload, all sent MSB first. Header 2'b01 marks data; header 2'b10 with payload IDLE_WORD marks idle. Headers 00 and 11 are bad.
- Reset (rst=0 at posedge):
  - TX shift register loads the idle frame, so tx_o=1 (first header bit).
  - TX bit counter=0; hold register invalid.
  - RX enters HUNT; good and bad counters 0.
  - channel_up, fifo_read_o, fifo_wren_o and fifo_data_o are 0.
- TX framing:
  - A 0..33 bit counter shifts one bit per cycle.
  - When the counter wraps (after bit 33), the next frame loads. If the hold register is valid it loads {01,hold} and clears hold-valid; otherwise it loads {10,IDLE_WORD}.
  - Frames are back-to-back with no gaps.
- TX prefetch:
  - fifo_read_o is a 1-cycle pulse, asserted only when channel_up=1, fifo_empty_i=0, hold invalid, and no read is outstanding.
  - fifo_data_i is captured into hold the next cycle.
  - Only one read is in flight at a time.
  - A frame already started is never modified.
  - If channel_up drops, no new reads occur; a valid hold word is still sent.
- RX uses a 34-bit shift register and a frame counter.
- RX HUNT state:
  - Every 34 bits, check the window.
  - On a valid idle frame, increment the good counter.
  - On any other content, clear the good counter and slip one bit: the next check comes after 35 bits.
  - When the good counter reaches the threshold (LOCK_CNT, or 2 if SIMULATION_P=1), go to LOCKED and set channel_up=1 the cycle after.
- RX LOCKED state:
  - Header 01: pulse fifo_wren_o for 1 cycle with fifo_data_o=payload, the cycle after the last payload bit is sampled. If fifo_full_i=1 in that cycle, the word is dropped and no write occurs.
  - Header 10: no write, regardless of payload.
  - Header 00 or 11: increment the bad counter.
  - Any 01/10 frame clears the bad counter.
  - When the bad counter reaches UNLOCK_CNT, go to HUNT, clear channel_up, clear the counters, and issue no write.
- fifo_data_o holds its last written value between strobes.
- Loopback latency: from the fifo_read_o pulse to fifo_wren_o is at most 2*34+3 cycles.
- Reset mid-operation: the in-flight frame and hold word are discarded; the upstream word already read is lost.

Test Plan:
- Loopback (tx_o->rx_i), SIMULATION_P=1, fifo_empty_i=1 -> channel_up=1 within 36*34+3 cycles of reset release; tx_o carries only idle frames; fifo_read_o stays 0; fifo_wren_o stays 0.
- Loopback, after lock, FIFO holding 0x00000001, 0xFFFFFFFF, 0xDEADBEEF -> exactly 3 fifo_read_o pulses and 3 fifo_wren_o pulses in that order with those values; empty afterwards -> idles only.
- FIFO non-empty before lock -> fifo_read_o stays 0 until channel_up=1.
- fifo_full_i=1 during the strobe of word 0x12345678 -> word dropped; the next word 0x0000ABCD is written normally.
- After lock, force rx_i=0 -> channel_up falls after UNLOCK_CNT(4) frames (≤ 4*34+2 cycles); releasing to loopback relocks.
- Assert rst=0 for 1 cycle mid-data-frame -> next cycle channel_up=0, fifo_wren_o=0, tx_o=1; link relocks and resumes from the next FIFO word.

Source files
------------

// File: rtl/serial_link_lane.sv
// Serial link lane: frames 32-bit FIFO words into 34-bit symbols on tx_o
// and aligns, locks and deframes the rx_i stream into a downstream FIFO.
module serial_link_lane #(
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] IDLE_WORD    = 32'hBC50_BC50,
    parameter int                LOCK_CNT     = 8,
    parameter int                UNLOCK_CNT   = 4,
    parameter bit                SIMULATION_P = 1'b0
) (
    input  logic              user_clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic              tx_o,
    output logic              channel_up,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_read_o,
    output logic [DATA_W-1:0] fifo_data_o,
    output logic              fifo_wren_o,
    input  logic              fifo_full_i
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int LOCK_THR = SIMULATION_P ? 2 : LOCK_CNT;

    localparam logic [CNT_W-1:0]   LAST       = CNT_W'(FRAME_W - 1);
    localparam logic [7:0]         LOCK_THR_C = 8'(LOCK_THR);
    localparam logic [7:0]         UNLOCK_C   = 8'(UNLOCK_CNT);
    localparam logic [FRAME_W-1:0] IDLE_FRAME = {2'b10, IDLE_WORD};

    typedef enum logic {
        HUNT,
        LOCKED
    } rx_state_e;

    logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic               rd_pend_q, rd_pend_d;

    logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    rx_state_e          state_q, state_d;
    logic [7:0]         good_q, good_d;
    logic [7:0]         bad_q, bad_d;
    logic               wr_pend_q, wr_pend_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic [1:0]         hdr;

    assign tx_o        = tx_sr_q[FRAME_W-1];
    assign channel_up  = (state_q == LOCKED);
    assign fifo_read_o = channel_up & ~fifo_empty_i & ~hold_vld_q & ~rd_pend_q;
    assign fifo_wren_o = wr_pend_q & ~fifo_full_i;
    assign fifo_data_o = fifo_wren_o ? word_q : out_q;
    assign hdr         = rx_sr_d[FRAME_W-1 -: 2];

    always_comb begin
        tx_sr_d    = {tx_sr_q[FRAME_W-2:0], 1'b0};
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        rd_pend_d  = fifo_read_o;
        if (rd_pend_q) begin
            hold_d     = fifo_data_i;
            hold_vld_d = 1'b1;
        end
        if (tx_cnt_q == LAST) begin
            tx_cnt_d = '0;
            if (hold_vld_q) begin
                tx_sr_d    = {2'b01, hold_q};
                hold_vld_d = 1'b0;
            end else begin
                tx_sr_d = IDLE_FRAME;
            end
        end
    end

    always_comb begin
        rx_sr_d   = {rx_sr_q[FRAME_W-2:0], rx_i};
        rx_cnt_d  = rx_cnt_q + CNT_W'(1);
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        wr_pend_d = 1'b0;
        word_d    = word_q;
        out_d     = fifo_wren_o ? word_q : out_q;
        if (rx_cnt_q == LAST) begin
            rx_cnt_d = '0;
            unique case (state_q)
                HUNT: begin
                    if (rx_sr_d == IDLE_FRAME) begin
                        if (good_q + 8'd1 == LOCK_THR_C) begin
                            state_d = LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + 8'd1;
                        end
                    end else begin
                        // all-ones wraps through zero: window slips one bit
                        good_d   = '0;
                        rx_cnt_d = '1;
                    end
                end
                LOCKED: begin
                    unique case (1'b1)
                        (hdr == 2'b01): begin
                            wr_pend_d = 1'b1;
                            word_d    = rx_sr_d[DATA_W-1:0];
                            bad_d     = '0;
                        end
                        (hdr == 2'b10): bad_d = '0;
                        default: begin
                            if (bad_q + 8'd1 == UNLOCK_C) begin
                                state_d = HUNT;
                                good_d  = '0;
                                bad_d   = '0;
                            end else begin
                                bad_d = bad_q + 8'd1;
                            end
                        end
                    endcase
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (!rst) begin
            tx_sr_q    <= IDLE_FRAME;
            tx_cnt_q   <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rx_sr_q    <= '0;
            rx_cnt_q   <= '0;
            state_q    <= HUNT;
            good_q     <= '0;
            bad_q      <= '0;
            wr_pend_q  <= 1'b0;
            word_q     <= '0;
            out_q      <= '0;
        end else begin
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rd_pend_q  <= rd_pend_d;
            rx_sr_q    <= rx_sr_d;
            rx_cnt_q   <= rx_cnt_d;
            state_q    <= state_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            wr_pend_q  <= wr_pend_d;
            word_q     <= word_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_serial_link_lane.sv
// Loopback bench for serial_link_lane: upstream FIFO model, word
// scoreboard and frame-phase reference for the idle stream.
module tb_serial_link_lane;

    logic        user_clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_i;
    logic        tx_o;
    logic        channel_up;
    logic [31:0] fifo_data_i = '0;
    logic        fifo_empty_i = 1'b1;
    logic        fifo_read_o;
    logic [31:0] fifo_data_o;
    logic        fifo_wren_o;
    logic        fifo_full_i = 1'b0;
    logic        rx_force = 1'b0;

    logic [33:0] idle_f = {2'b10, 32'hBC50_BC50};

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int rst_cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit idle_chk = 1'b0;

    logic [31:0] in_q[$];
    logic [31:0] fq[$];
    logic [31:0] exp_q[$];
    int          stamp_q[$];

    assign rx_i = rx_force ? 1'b0 : tx_o;

    always #5 user_clk = ~user_clk;

    serial_link_lane #(
        .SIMULATION_P(1'b1)
    ) dut (
        .user_clk    (user_clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .tx_o        (tx_o),
        .channel_up  (channel_up),
        .fifo_data_i (fifo_data_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_read_o (fifo_read_o),
        .fifo_data_o (fifo_data_o),
        .fifo_wren_o (fifo_wren_o),
        .fifo_full_i (fifo_full_i)
    );

    // FIFO model and scoreboard: sample mid-cycle, update after the edge
    initial begin : mon
        bit          rd_now;
        logic [31:0] w;
        int          k;
        forever begin
            @(negedge user_clk);
            rd_now = fifo_read_o;
            if (rd_now) begin
                vectors++;
                if (channel_up !== 1'b1) begin
                    errors++;
                    $display("FAIL read_gate: fifo_read_o=1 with channel_up=%b, required 1", channel_up);
                end
            end
            if (fifo_wren_o === 1'b1) begin
                wr_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write: got %h, required no write", fifo_data_o);
                end else begin
                    w = exp_q.pop_front();
                    k = stamp_q.pop_front();
                    if (fifo_data_o !== w) begin
                        errors++;
                        $display("FAIL wr_data: got %h, required %h", fifo_data_o, w);
                    end
                    if (cyc - k > 2 * 34 + 3) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, required <= 71", cyc - k);
                    end
                end
            end
            if (idle_chk) begin
                k = (cyc - rst_cyc) % 34;
                vectors++;
                if (tx_o !== idle_f[33-k]) begin
                    errors++;
                    $display("FAIL idle_bit: bit %0d got %b, required %b", k, tx_o, idle_f[33-k]);
                end
            end
            @(posedge user_clk);
            #1;
            cyc++;
            if (rst === 1'b0) rst_cyc = cyc;
            if (rd_now) begin
                rd_cnt++;
                w = fq.pop_front();
                exp_q.push_back(w);
                stamp_q.push_back(cyc - 1);
                fifo_data_i = w;
            end else begin
                fifo_data_i = $urandom;
            end
            while (in_q.size() > 0) fq.push_back(in_q.pop_front());
            fifo_empty_i = (fq.size() == 0);
        end
    end

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while ((in_q.size() + fq.size() + exp_q.size()) != 0 && n < budget) begin
            @(negedge user_clk);
            n++;
        end
        ok = (in_q.size() + fq.size() + exp_q.size()) == 0;
    endtask

    task automatic wait_lock(input int budget, output bit ok);
        int n = 0;
        while (channel_up !== 1'b1 && n < budget) begin
            @(negedge user_clk);
            n++;
        end
        ok = (channel_up === 1'b1);
    endtask

    task automatic test_reset();
        idle_chk = 1'b0;
        @(negedge user_clk);
        rst = 1'b0;
        repeat (3) @(negedge user_clk);
        vectors++;
        if ({tx_o, channel_up, fifo_read_o, fifo_wren_o} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outs: tx/up/rd/wr got %b%b%b%b, required 1000",
                     tx_o, channel_up, fifo_read_o, fifo_wren_o);
        end
        vectors++;
        if (fifo_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 00000000", fifo_data_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_lock();
        bit ok;
        idle_chk = 1'b1;
        wait_lock(36 * 34 + 3, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL lock_time: channel_up got 0, required 1 within 1227 cycles");
        end
        repeat (68) @(negedge user_clk);
        idle_chk = 1'b0;
        vectors++;
        if (rd_cnt != 0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL idle_traffic: reads %0d writes %0d, required 0 0", rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int r0 = rd_cnt;
        int w0 = wr_cnt;
        in_q.push_back(32'h0000_0001);
        in_q.push_back(32'hFFFF_FFFF);
        in_q.push_back(32'hDEAD_BEEF);
        wait_idle(400, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_drain: %0d words pending, required 0", fq.size() + exp_q.size());
        end
        vectors++;
        if (rd_cnt - r0 != 3 || wr_cnt - w0 != 3) begin
            errors++;
            $display("FAIL b2b_count: reads %0d writes %0d, required 3 3", rd_cnt - r0, wr_cnt - w0);
        end
        idle_chk = 1'b1;
        repeat (68) @(negedge user_clk);
        idle_chk = 1'b0;
        vectors++;
        if (rd_cnt - r0 != 3) begin
            errors++;
            $display("FAIL b2b_after: reads %0d, required 3", rd_cnt - r0);
        end
    endtask

    task automatic test_full();
        bit ok;
        int n = 0;
        int r0 = rd_cnt;
        int w0 = wr_cnt;
        @(posedge user_clk);
        #2;
        fifo_full_i = 1'b1;
        in_q.push_back(32'h1234_5678);
        while (rd_cnt == r0 && n < 200) begin
            @(negedge user_clk);
            n++;
        end
        repeat (80) @(negedge user_clk);
        vectors++;
        if (rd_cnt - r0 != 1 || wr_cnt != w0) begin
            errors++;
            $display("FAIL full_drop: reads %0d writes %0d, required 1 0", rd_cnt - r0, wr_cnt - w0);
        end
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(stamp_q.pop_front());
        end
        @(posedge user_clk);
        #2;
        fifo_full_i = 1'b0;
        in_q.push_back(32'h0000_ABCD);
        wait_idle(300, ok);
        vectors++;
        if (!ok || wr_cnt - w0 != 1) begin
            errors++;
            $display("FAIL full_next: writes %0d, required 1", wr_cnt - w0);
        end
    endtask

    task automatic test_random();
        bit ok;
        int w0 = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            in_q.push_back($urandom);
            repeat ($urandom_range(0, 60)) @(negedge user_clk);
        end
        wait_idle(20 * 75, ok);
        vectors++;
        if (!ok || wr_cnt - w0 != 20) begin
            errors++;
            $display("FAIL random_count: writes %0d, required 20", wr_cnt - w0);
        end
    endtask

    task automatic test_unlock();
        bit ok;
        int n = 0;
        @(negedge user_clk);
        while (((cyc - rst_cyc) % 34) != 0) @(negedge user_clk);
        rx_force = 1'b1;
        while (channel_up === 1'b1 && n < 300) begin
            @(negedge user_clk);
            n++;
        end
        vectors++;
        if (channel_up !== 1'b0 || n < 4 * 34 - 2 || n > 4 * 34 + 2) begin
            errors++;
            $display("FAIL unlock_time: fell after %0d cycles, required 134..138", n);
        end
        rx_force = 1'b0;
        wait_lock(36 * 34 + 40, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL relock: channel_up got 0, required 1");
        end
    endtask

    task automatic test_pre_lock();
        bit ok;
        int bad_rd = 0;
        int n = 0;
        int w0 = wr_cnt;
        @(negedge user_clk);
        rst = 1'b0;
        in_q.push_back($urandom);
        in_q.push_back(32'hA5A5_0F0F);
        @(negedge user_clk);
        rst = 1'b1;
        exp_q.delete();
        stamp_q.delete();
        while (channel_up !== 1'b1 && n < 36 * 34 + 3) begin
            if (fifo_read_o !== 1'b0) bad_rd++;
            @(negedge user_clk);
            n++;
        end
        vectors++;
        if (bad_rd != 0 || channel_up !== 1'b1) begin
            errors++;
            $display("FAIL prelock_read: reads %0d up %b, required 0 1", bad_rd, channel_up);
        end
        wait_idle(300, ok);
        vectors++;
        if (!ok || wr_cnt - w0 != 2) begin
            errors++;
            $display("FAIL prelock_count: writes %0d, required 2", wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        int r0 = rd_cnt;
        int r1;
        int w1;
        for (int i = 0; i < 6; i++) in_q.push_back($urandom);
        while (rd_cnt == r0 && n < 200) begin
            @(negedge user_clk);
            n++;
        end
        repeat (40) @(negedge user_clk);
        rst = 1'b0;
        @(negedge user_clk);
        vectors++;
        if ({channel_up, fifo_wren_o, tx_o} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset: up/wr/tx got %b%b%b, required 001",
                     channel_up, fifo_wren_o, tx_o);
        end
        rst = 1'b1;
        exp_q.delete();
        stamp_q.delete();
        r1 = rd_cnt;
        w1 = wr_cnt;
        wait_lock(36 * 34 + 3, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_relock: channel_up got 0, required 1");
        end
        wait_idle(6 * 75, ok);
        repeat (100) @(negedge user_clk);
        vectors++;
        if (!ok || wr_cnt - w1 != rd_cnt - r1 || rd_cnt - r0 != 6) begin
            errors++;
            $display("FAIL mid_resume: writes %0d reads %0d total %0d, required writes=reads total 6",
                     wr_cnt - w1, rd_cnt - r1, rd_cnt - r0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock();
        test_back_to_back();
        test_full();
        test_random();
        test_unlock();
        test_pre_lock();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
